regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised integer register file for the RV32I core: two combinational read ports and one synchronous write port.
- Optional x0 hardwiring and same-cycle write-to-read bypass.
- Integrated per-register busy scoreboard: decode marks a destination pending, writeback clears it.
- Sits between decode (A1/A2 reads, busy query and set) and writeback (A3/WD3/WE3).
- Replaces the fixed 32x32 register file.

Parameters:
- XLEN, 32, data width of each register and of WD3/RD1/RD2.
- NREG, 32, number of registers; power of two, 2..32. Address width AW = clog2(NREG), derived internally.
- ZERO_REG, 1, when 1, register 0 reads as 0 and ignores writes and busy sets.
- BYPASS, 1, when 1, a write in the current cycle is forwarded combinationally to matching read ports.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-low reset.
- A1  in  AW  read address, port 1.
- A2  in  AW  read address, port 2.
- RD1  out  XLEN  read data, port 1.
- RD2  out  XLEN  read data, port 2.
- WE3  in  1  write enable (writeback).
- A3  in  AW  write address.
- WD3  in  XLEN  write data.
- set_busy  in  1  mark busy_addr as having an outstanding producer.
- busy_addr  in  AW  destination being issued.
- flush  in  1  clear all busy bits (pipeline flush).
- busy1  out  1  A1 has an outstanding producer not satisfied this cycle.
- busy2  out  1  A2 has an outstanding producer not satisfied this cycle.

Behaviour:
- Reset (rst=0, asynchronous, any time):
  - all NREG registers go to 0; all busy bits go to 0.
  - RD1/RD2 then read 0 (unless bypass is active) and busy1/busy2 read 0.
  - Writes, sets and flush are ignored while rst=0.
  - Release is synchronous to the next rising edge.
- Reads are combinational, zero latency:
  - RDn = reg[An].
  - If BYPASS=1 and WE3=1 and A3==An and the write is not suppressed, RDn = WD3.
  - If ZERO_REG=1 and An==0, RDn = 0 regardless of bypass.
- Write: at posedge, if WE3=1 then reg[A3] <= WD3, except A3==0 with ZERO_REG=1, which is dropped. With ZERO_REG=0, register 0 is an ordinary register.
- Busy bit next-state per register i, in priority order:
  1. flush=1: busy[i] <= 0 for all i. flush overrides a same-cycle set.
  2. set_busy=1 and busy_addr==i: busy[i] <= 1. Set wins over a same-cycle writeback clear of the same register, because a new producer supersedes the old one.
  3. WE3=1 and A3==i: busy[i] <= 0.
  4. Otherwise hold.
  - Register 0 is never set busy when ZERO_REG=1.
- Busy outputs: busyn = busy[An] & ~(BYPASS & WE3 & A3==An).
  - The writeback in progress satisfies the read in the same cycle.
  - With BYPASS=0, busyn = busy[An] until the edge after the write.
  - busyn = 0 when An==0 and ZERO_REG=1.
- A write to a non-busy register is legal: data updates, busy stays 0.
- A1==A2 is legal: both ports return identical data and busy.
- Address values at or above NREG cannot occur because AW is exact; no range check.

Test Plan:
1. Reset then write: rst=0 for 2 cycles, release; WE3=1, A3=1, WD3=32'h00203400; next cycle A1=1 -> RD1=32'h00203400. Before the write, A1=1 -> RD1=0.
2. Bypass and x0: WE3=1, A3=5, WD3=32'hDEADBEEF with A1=5 in the same cycle -> RD1=32'hDEADBEEF before the edge. WE3=1, A3=0, WD3=32'hFFFFFFFF, then A2=0 -> RD2=0.
3. Scoreboard life cycle: set_busy=1, busy_addr=7; next cycle A1=7 -> busy1=1. Writeback WE3=1, A3=7, WD3=32'h12 -> busy1=0 in that same cycle and RD1=32'h12. After the edge busy1 stays 0.
4. Set/clear collision: busy[9]=1; same cycle set_busy=1, busy_addr=9 and WE3=1, A3=9, WD3=32'h55 -> after the edge busy[9]=1 (A2=9 -> busy2=1) and reg[9]=32'h55.
5. Flush priority: busy set on regs 3 and 4; flush=1 with set_busy=1, busy_addr=6 -> after the edge busy1/busy2=0 for A1=3, A2=6; register contents unchanged.
6. Async reset mid-operation: reg[2]=32'h01010101, busy[2]=1; drop rst between clock edges -> RD1 (A1=2)=0 and busy1=0 immediately, without waiting for an edge. A write asserted during reset is lost. Also with BYPASS=0, NREG=16: scenario 3 gives busy1=1 in the writeback cycle and 0 after the edge.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - RV32I integer register file with per-register busy scoreboard
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        asynchronous active-low reset (registers and busy bits to 0)
//   A1, A2     combinational read addresses
//   RD1, RD2   read data (zero-latency, optional writeback bypass)
//   WE3, A3,   writeback port: write enable, address, data
//   WD3
//   set_busy,  decode marks busy_addr as having an outstanding producer
//   busy_addr
//   flush      clears every busy bit
//   busy1,     read port n has an outstanding producer not satisfied this cycle
//   busy2

module regfile_scoreboard #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  input  logic            WE3,
  input  logic [AW-1:0]   A3,
  input  logic [XLEN-1:0] WD3,
  input  logic            set_busy,
  input  logic [AW-1:0]   busy_addr,
  input  logic            flush,
  output logic            busy1,
  output logic            busy2
);

  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BP = (BYPASS != 0);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;

  logic            wr_ok;
  logic            set_ok;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  // Writes and busy sets aimed at a hardwired x0 are dropped outright, so
  // neither the bypass path nor the scoreboard ever sees them.
  assign wr_ok    = WE3 && !(ZR && (A3 == '0));
  assign set_ok   = set_busy && !(ZR && (busy_addr == '0));
  assign set_mask = set_ok ? (NREG'(1) << busy_addr) : '0;
  assign clr_mask = wr_ok  ? (NREG'(1) << A3)        : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      if (wr_ok) begin
        regs[A3] <= WD3;
      end
      // Flush beats everything; otherwise a new producer (set) supersedes
      // the writeback clear of the same register.
      if (flush) begin
        busy <= '0;
      end else begin
        busy <= (busy & ~clr_mask) | set_mask;
      end
    end
  end

  logic fwd1, fwd2;
  logic zero1, zero2;

  assign fwd1  = BP && wr_ok && (A3 == A1);
  assign fwd2  = BP && wr_ok && (A3 == A2);
  assign zero1 = ZR && (A1 == '0);
  assign zero2 = ZR && (A2 == '0);

  always_comb begin
    RD1 = regs[A1];
    if (zero1) begin
      RD1 = '0;
    end else if (fwd1) begin
      RD1 = WD3;
    end
  end

  always_comb begin
    RD2 = regs[A2];
    if (zero2) begin
      RD2 = '0;
    end else if (fwd2) begin
      RD2 = WD3;
    end
  end

  // The writeback in flight this cycle satisfies the dependency when bypassed.
  assign busy1 = !zero1 && busy[A1] && !fwd1;
  assign busy2 = !zero2 && busy[A2] && !fwd2;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - scoreboard bench for regfile_scoreboard (two configurations)

module tb_regfile_scoreboard;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        b1;
    logic        b2;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  a1 = '0, a2 = '0, a3 = '0, ba = '0;
  logic [31:0] wd = '0;
  logic        we = 1'b0, setb = 1'b0, fl = 1'b0;

  logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1;
  logic        b1_0, b2_0, b1_1, b2_1;

  always #5 clk = ~clk;

  // Default build: 32 regs, x0 hardwired, bypass on.
  regfile_scoreboard #(.XLEN(32), .NREG(32), .ZERO_REG(1), .BYPASS(1)) dut0 (
    .clk(clk), .rst(rst), .A1(a1), .A2(a2), .RD1(rd1_0), .RD2(rd2_0),
    .WE3(we), .A3(a3), .WD3(wd), .set_busy(setb), .busy_addr(ba),
    .flush(fl), .busy1(b1_0), .busy2(b2_0)
  );

  // Alternate build: 16 regs, x0 ordinary, no bypass.
  regfile_scoreboard #(.XLEN(32), .NREG(16), .ZERO_REG(0), .BYPASS(0)) dut1 (
    .clk(clk), .rst(rst), .A1(a1[3:0]), .A2(a2[3:0]), .RD1(rd1_1), .RD2(rd2_1),
    .WE3(we), .A3(a3[3:0]), .WD3(wd), .set_busy(setb), .busy_addr(ba[3:0]),
    .flush(fl), .busy1(b1_1), .busy2(b2_1)
  );

  // Reference model: plain arrays, one per configuration.
  int          cfg_nreg [2] = '{32, 16};
  bit          cfg_zero [2] = '{1'b1, 1'b0};
  bit          cfg_byp  [2] = '{1'b1, 1'b0};
  logic [31:0] mreg  [2][32];
  bit          mbusy [2][32];

  obs_t q0[$];
  obs_t q1[$];
  event drv_ev;
  bit   drv_done = 1'b0;

  int passed = 0;
  int total  = 0;

  function automatic int msk(int k, logic [4:0] a);
    return int'(a) % cfg_nreg[k];
  endfunction

  function automatic bit write_kept(int k);
    return we && !(cfg_zero[k] && msk(k, a3) == 0);
  endfunction

  function automatic obs_t predict(int k);
    obs_t o;
    int   ra [2];
    logic [31:0] d [2];
    bit   b [2];
    ra[0] = msk(k, a1);
    ra[1] = msk(k, a2);
    for (int p = 0; p < 2; p++) begin
      bit fwd;
      fwd  = cfg_byp[k] && write_kept(k) && msk(k, a3) == ra[p];
      d[p] = fwd ? wd : mreg[k][ra[p]];
      b[p] = mbusy[k][ra[p]] && !fwd;
      if (cfg_zero[k] && ra[p] == 0) begin
        d[p] = '0;
        b[p] = 1'b0;
      end
    end
    o.rd1 = d[0];
    o.rd2 = d[1];
    o.b1  = b[0];
    o.b2  = b[1];
    return o;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++) begin
        mreg[k][i]  = '0;
        mbusy[k][i] = 1'b0;
      end
  endfunction

  function automatic void model_edge();
    for (int k = 0; k < 2; k++) begin
      if (write_kept(k)) mreg[k][msk(k, a3)] = wd;
      if (fl) begin
        for (int i = 0; i < 32; i++) mbusy[k][i] = 1'b0;
      end else begin
        if (we) mbusy[k][msk(k, a3)] = 1'b0;
        if (setb && !(cfg_zero[k] && msk(k, ba) == 0)) mbusy[k][msk(k, ba)] = 1'b1;
      end
    end
  endfunction

  // Drive one cycle on the falling edge, queue the expected outputs, then
  // advance the model to represent the coming rising edge.
  task automatic cyc(input logic r, input logic we_i, input logic [4:0] a3_i,
                     input logic [31:0] wd_i, input logic [4:0] a1_i, input logic [4:0] a2_i,
                     input logic set_i, input logic [4:0] ba_i, input logic fl_i);
    @(negedge clk);
    rst = r; we = we_i; a3 = a3_i; wd = wd_i; a1 = a1_i; a2 = a2_i;
    setb = set_i; ba = ba_i; fl = fl_i;
    if (!r) model_reset();
    q0.push_back(predict(0));
    q1.push_back(predict(1));
    -> drv_ev;
    if (r) model_edge();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(drv_ev);
      #2;
      if (q0.size() == 0 || q1.size() == 0) begin
        check("queue_underflow", 32'(q0.size()), 32'd1);
      end else begin
        e = q0.pop_front();
        check("c0_rd1", rd1_0, e.rd1);
        check("c0_rd2", rd2_0, e.rd2);
        check("c0_busy1", 32'(b1_0), 32'(e.b1));
        check("c0_busy2", 32'(b2_0), 32'(e.b2));
        e = q1.pop_front();
        check("c1_rd1", rd1_1, e.rd1);
        check("c1_rd2", rd2_1, e.rd2);
        check("c1_busy1", 32'(b1_1), 32'(e.b1));
        check("c1_busy2", 32'(b2_1), 32'(e.b2));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1);
  end

  initial begin : stimulus
    model_reset();
    // Reset held for two cycles.
    cyc(0, 0, 0, 0, 1, 2, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 2, 0, 0, 0);
    // Read before write, write, read back.
    cyc(1, 0, 0, 0, 1, 1, 0, 0, 0);
    cyc(1, 1, 1, 32'h00203400, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 1, 0, 0, 0);
    // Bypass, then write to x0.
    cyc(1, 1, 5, 32'hDEADBEEF, 5, 5, 0, 0, 0);
    cyc(1, 1, 0, 32'hFFFFFFFF, 5, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Scoreboard life cycle on x7.
    cyc(1, 0, 0, 0, 7, 7, 1, 7, 0);
    cyc(1, 0, 0, 0, 7, 7, 0, 0, 0);
    cyc(1, 1, 7, 32'h12, 7, 7, 0, 0, 0);
    cyc(1, 0, 0, 0, 7, 7, 0, 0, 0);
    // Set and writeback clear collide on x9.
    cyc(1, 0, 0, 0, 9, 9, 1, 9, 0);
    cyc(1, 1, 9, 32'h55, 9, 9, 1, 9, 0);
    cyc(1, 0, 0, 0, 9, 9, 0, 0, 0);
    // Flush overrides a same-cycle set.
    cyc(1, 1, 3, 32'h33, 3, 4, 1, 3, 0);
    cyc(1, 0, 0, 0, 3, 4, 1, 4, 0);
    cyc(1, 0, 0, 0, 3, 6, 1, 6, 1);
    cyc(1, 0, 0, 0, 3, 6, 0, 0, 0);
    cyc(1, 0, 0, 0, 4, 9, 0, 0, 0);
    // Reset mid-operation, with a write that must be lost.
    cyc(1, 1, 2, 32'h01010101, 0, 0, 1, 2, 0);
    cyc(1, 0, 0, 0, 2, 2, 0, 0, 0);
    cyc(0, 1, 2, 32'hAAAA5555, 2, 2, 1, 2, 0);
    cyc(1, 0, 0, 0, 2, 2, 0, 0, 0);
    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 59) != 0), $urandom_range(0, 1), 5'($urandom),
          $urandom, 5'($urandom), 5'($urandom),
          ($urandom_range(0, 2) == 0), 5'($urandom), ($urandom_range(0, 15) == 0));
    end
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check("queue_drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
